// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, fixed-latency SRAM between the instruction-fetch
//   port and the data port. One requester is granted at a time; each access
//   spends WAIT_CYCLES cycles in ACCESS and then one cycle in DONE, where the
//   granted port's ready pulses. When both ports are requesting, the one that
//   was not granted last wins.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   if_req/if_addr                fetch request (read only), held until if_ready
//   if_rdata/if_ready/if_stall    fetched word, completion pulse, pipeline stall
//   mem_req/mem_we/mem_addr/
//   mem_wdata                     data request, held until mem_ready
//   mem_rdata/mem_ready/mem_stall load data, completion pulse, pipeline stall
//   sram_addr/sram_wdata          latched address / write data of current access
//   sram_we/sram_oe               strobes, high for the whole ACCESS phase
//   sram_rdata                    SRAM read bus
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we,
  output logic              sram_oe,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int unsigned      CNT_W    = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {PORT_IF, PORT_MEM} port_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  port_t            lat_port;
  port_t            last_grant;
  port_t            grant_port;
  logic             lat_we;
  logic             any_req;
  logic             cnt_done;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    any_req  = if_req | mem_req;
    cnt_done = (cnt == CNT_LAST);
    if (mem_req && (!if_req || (last_grant == PORT_IF))) grant_port = PORT_MEM;
    else                                                  grant_port = PORT_IF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)  state_nxt = ACCESS;
      ACCESS:  if (cnt_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      lat_port   <= PORT_IF;
      last_grant <= PORT_IF;
      lat_we     <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            cnt      <= '0;
            lat_port <= grant_port;
            if (grant_port == PORT_MEM) begin
              sram_addr  <= mem_addr;
              sram_wdata <= mem_wdata;
              lat_we     <= mem_we;
            end else begin
              sram_addr <= if_addr;
              lat_we    <= 1'b0;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt_done) begin
            if (!lat_we) begin
              if (lat_port == PORT_MEM) mem_rdata <= sram_rdata;
              else                      if_rdata  <= sram_rdata;
            end
            last_grant <= lat_port;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes and ready are decoded from registered state only, so an
  // asynchronous reset drops them in the same cycle.
  always_comb begin
    sram_we   = (state == ACCESS) &  lat_we;
    sram_oe   = (state == ACCESS) & ~lat_we;
    if_ready  = (state == DONE) & (lat_port == PORT_IF);
    mem_ready = (state == DONE) & (lat_port == PORT_MEM);
    if_stall  = if_req  & ~if_ready;
    mem_stall = mem_req & ~mem_ready;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Two arbiters (WAIT_CYCLES = 4 and WAIT_CYCLES = 1) driven by directed
//   sequences. A transaction-level model tracks, per instance, the elapsed
//   cycles since each grant and an SRAM lookup table; every cycle the DUT
//   outputs are compared against it. Hand-computed per-cycle traces pin the
//   model for the documented scenarios.
module tb_mem_port_arbiter;

  localparam int W0 = 4;
  localparam int W1 = 1;

  logic        clk;
  logic        rst;
  logic        if_req     [2];
  logic [31:0] if_addr    [2];
  logic [31:0] if_rdata   [2];
  logic        if_ready   [2];
  logic        if_stall   [2];
  logic        mem_req    [2];
  logic        mem_we     [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_wdata  [2];
  logic [31:0] mem_rdata  [2];
  logic        mem_ready  [2];
  logic        mem_stall  [2];
  logic [31:0] sram_addr  [2];
  logic [31:0] sram_wdata [2];
  logic        sram_we    [2];
  logic        sram_oe    [2];
  logic [31:0] sram_rdata [2];

  int n_vec = 0;
  int n_err = 0;

  // SRAM contents seen by both arbiters
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0010: rom = 32'hE3A0_0001;
      32'h0000_0020: rom = 32'hA5A5_0002;
      32'h0000_0200: rom = 32'h1234_5678;
      default:       rom = a ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  function automatic int wcyc(input int i);
    wcyc = (i == 0) ? W0 : W1;
  endfunction

  assign sram_rdata[0] = rom(sram_addr[0]);
  assign sram_rdata[1] = rom(sram_addr[1]);

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W0)) u0 (
    .clk(clk), .rst(rst),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]),
    .if_ready(if_ready[0]), .if_stall(if_stall[0]),
    .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .mem_ready(mem_ready[0]), .mem_stall(mem_stall[0]),
    .sram_addr(sram_addr[0]), .sram_wdata(sram_wdata[0]),
    .sram_we(sram_we[0]), .sram_oe(sram_oe[0]), .sram_rdata(sram_rdata[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W1)) u1 (
    .clk(clk), .rst(rst),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]),
    .if_ready(if_ready[1]), .if_stall(if_stall[1]),
    .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .mem_ready(mem_ready[1]), .mem_stall(mem_stall[1]),
    .sram_addr(sram_addr[1]), .sram_wdata(sram_wdata[1]),
    .sram_we(sram_we[1]), .sram_oe(sram_oe[1]), .sram_rdata(sram_rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_t counts cycles since the grant cycle: 1..W is the SRAM access,
  // W+1 is the ready cycle; after that the port is free again.
  bit          m_busy [2];
  int          m_t    [2];
  bit          m_port [2];   // 1 = data port
  bit          m_we   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdat [2];
  logic [31:0] m_ifd  [2];
  logic [31:0] m_memd [2];
  bit          m_last [2];   // 1 = data port was granted last

  always @(posedge clk or negedge rst) begin
    bit pm;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0; m_t[i] <= 0; m_port[i] <= 1'b0; m_we[i] <= 1'b0;
        m_addr[i] <= '0; m_wdat[i] <= '0; m_ifd[i] <= '0; m_memd[i] <= '0;
        m_last[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          if (if_req[i] || mem_req[i]) begin
            pm = mem_req[i] && !(if_req[i] && m_last[i]);
            m_busy[i] <= 1'b1;
            m_t[i]    <= 1;
            m_port[i] <= pm;
            m_we[i]   <= pm && mem_we[i];
            m_addr[i] <= pm ? mem_addr[i] : if_addr[i];
            if (pm) m_wdat[i] <= mem_wdata[i];
          end
        end else begin
          if (m_t[i] == wcyc(i)) begin
            if (!m_we[i]) begin
              if (m_port[i]) m_memd[i] <= rom(m_addr[i]);
              else           m_ifd[i]  <= rom(m_addr[i]);
            end
            m_last[i] <= m_port[i];
          end
          if (m_t[i] == wcyc(i) + 1) m_busy[i] <= 1'b0;
          else                       m_t[i]    <= m_t[i] + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit acc, rdy, e_ifr, e_mr;
    for (int i = 0; i < 2; i++) begin
      acc   = m_busy[i] && (m_t[i] <= wcyc(i));
      rdy   = m_busy[i] && (m_t[i] == wcyc(i) + 1);
      e_ifr = rdy && !m_port[i];
      e_mr  = rdy && m_port[i];
      chk($sformatf("u%0d.sram_oe", i),    64'(sram_oe[i]),    64'(acc && !m_we[i]));
      chk($sformatf("u%0d.sram_we", i),    64'(sram_we[i]),    64'(acc && m_we[i]));
      chk($sformatf("u%0d.if_ready", i),   64'(if_ready[i]),   64'(e_ifr));
      chk($sformatf("u%0d.mem_ready", i),  64'(mem_ready[i]),  64'(e_mr));
      chk($sformatf("u%0d.if_stall", i),   64'(if_stall[i]),   64'(if_req[i] && !e_ifr));
      chk($sformatf("u%0d.mem_stall", i),  64'(mem_stall[i]),  64'(mem_req[i] && !e_mr));
      chk($sformatf("u%0d.sram_addr", i),  64'(sram_addr[i]),  64'(m_addr[i]));
      chk($sformatf("u%0d.sram_wdata", i), 64'(sram_wdata[i]), 64'(m_wdat[i]));
      chk($sformatf("u%0d.if_rdata", i),   64'(if_rdata[i]),   64'(m_ifd[i]));
      chk($sformatf("u%0d.mem_rdata", i),  64'(mem_rdata[i]),  64'(m_memd[i]));
    end
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] oe_tr, we_tr, ifr_tr, mr_tr, ifs_tr, ms_tr;

  // Entered at posedge+1 of cycle 0 with inputs already set. Records one
  // bit per cycle of each strobe; requesters drop req in the cycle after
  // their ready unless rearm keeps them requesting back to back.
  task automatic watch(input int inst, input int ncyc, input bit rearm,
                       input int rst_on, input int rst_off);
    bit fr, mr;
    oe_tr = '0; we_tr = '0; ifr_tr = '0; mr_tr = '0; ifs_tr = '0; ms_tr = '0;
    for (int k = 0; k < ncyc; k++) begin
      if (k == rst_on)  rst = 1'b0;
      if (k == rst_off) rst = 1'b1;
      @(negedge clk);
      oe_tr[k]  = sram_oe[inst];
      we_tr[k]  = sram_we[inst];
      ifr_tr[k] = if_ready[inst];
      mr_tr[k]  = mem_ready[inst];
      ifs_tr[k] = if_stall[inst];
      ms_tr[k]  = mem_stall[inst];
      fr = if_ready[inst];
      mr = mem_ready[inst];
      @(posedge clk); #1;
      if (!rearm) begin
        if (fr) if_req[inst]  = 1'b0;
        if (mr) mem_req[inst] = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if_req[i] = 1'b0; if_addr[i] = '0;
      mem_req[i] = 1'b0; mem_we[i] = 1'b0; mem_addr[i] = '0; mem_wdata[i] = '0;
    end

    // Reset with both requests held
    if_req[0] = 1'b1; if_addr[0] = 32'h20;
    mem_req[0] = 1'b1; mem_addr[0] = 32'h200;
    repeat (3) begin
      @(negedge clk);
      chk("reset.flags",
          64'({sram_oe[0], sram_we[0], if_ready[0], mem_ready[0], if_stall[0], mem_stall[0]}),
          64'(6'b000011));
      chk("reset.regs",
          64'(if_rdata[0] | mem_rdata[0] | sram_addr[0] | sram_wdata[0]), 64'(0));
    end
    @(posedge clk); #1;
    rst = 1'b1;

    // Contention out of reset: MEM first, IF granted in cycle 6
    watch(0, 13, 1'b0, -1, -1);
    chk("contend.mem_ready", 64'(mr_tr),  64'(32'h0000_0020));
    chk("contend.if_ready",  64'(ifr_tr), 64'(32'h0000_0800));
    chk("contend.oe",        64'(oe_tr),  64'(32'h0000_079E));
    chk("contend.mem_stall", 64'(ms_tr),  64'(32'h0000_001F));
    chk("contend.if_stall",  64'(ifs_tr), 64'(32'h0000_07FF));
    chk("contend.mem_rdata", 64'(mem_rdata[0]), 64'(32'h1234_5678));
    chk("contend.if_rdata",  64'(if_rdata[0]),  64'(32'hA5A5_0002));

    // Second simultaneous pair: IF was last, so MEM wins again
    if_req[0] = 1'b1; mem_req[0] = 1'b1;
    watch(0, 13, 1'b0, -1, -1);
    chk("pair2.mem_ready", 64'(mr_tr),  64'(32'h0000_0020));
    chk("pair2.if_ready",  64'(ifr_tr), 64'(32'h0000_0800));

    // Single fetch
    if_addr[0] = 32'h10; if_req[0] = 1'b1;
    watch(0, 7, 1'b0, -1, -1);
    chk("fetch.oe",       64'(oe_tr),  64'(32'h0000_001E));
    chk("fetch.we",       64'(we_tr),  64'(0));
    chk("fetch.if_ready", 64'(ifr_tr), 64'(32'h0000_0020));
    chk("fetch.if_stall", 64'(ifs_tr), 64'(32'h0000_001F));
    chk("fetch.if_rdata", 64'(if_rdata[0]), 64'(32'hE3A0_0001));
    chk("fetch.addr",     64'(sram_addr[0]), 64'(32'h10));

    // Data write: mem_rdata keeps the earlier load value
    mem_we[0] = 1'b1; mem_addr[0] = 32'h100; mem_wdata[0] = 32'hDEAD_BEEF; mem_req[0] = 1'b1;
    watch(0, 7, 1'b0, -1, -1);
    chk("write.we",        64'(we_tr), 64'(32'h0000_001E));
    chk("write.oe",        64'(oe_tr), 64'(0));
    chk("write.mem_ready", 64'(mr_tr), 64'(32'h0000_0020));
    chk("write.mem_rdata", 64'(mem_rdata[0]),  64'(32'h1234_5678));
    chk("write.addr",      64'(sram_addr[0]),  64'(32'h100));
    chk("write.wdata",     64'(sram_wdata[0]), 64'(32'hDEAD_BEEF));
    mem_we[0] = 1'b0;

    // Reset in cycle 2 of a fetch, released in cycle 4, request held
    if_addr[0] = 32'h10; if_req[0] = 1'b1;
    watch(0, 11, 1'b0, 2, 4);
    chk("rstmid.if_ready", 64'(ifr_tr), 64'(32'h0000_0200));
    chk("rstmid.oe",       64'(oe_tr),  64'(32'h0000_01E2));
    chk("rstmid.if_stall", 64'(ifs_tr), 64'(32'h0000_01FF));
    chk("rstmid.if_rdata", 64'(if_rdata[0]), 64'(32'hE3A0_0001));

    // WAIT_CYCLES = 1: single read
    if_addr[1] = 32'h10; if_req[1] = 1'b1;
    watch(1, 4, 1'b0, -1, -1);
    chk("w1.oe",       64'(oe_tr),  64'(32'h0000_0002));
    chk("w1.if_ready", 64'(ifr_tr), 64'(32'h0000_0004));
    chk("w1.if_rdata", 64'(if_rdata[1]), 64'(32'hE3A0_0001));

    // WAIT_CYCLES = 1: both held continuously, ready every 3 cycles
    if_addr[1] = 32'h20; mem_addr[1] = 32'h200; mem_we[1] = 1'b0;
    if_req[1] = 1'b1; mem_req[1] = 1'b1;
    watch(1, 13, 1'b1, -1, -1);
    chk("w1alt.mem_ready", 64'(mr_tr),  64'(32'h0000_0104));
    chk("w1alt.if_ready",  64'(ifr_tr), 64'(32'h0000_0820));
    chk("w1alt.mem_rdata", 64'(mem_rdata[1]), 64'(32'h1234_5678));
    chk("w1alt.if_rdata",  64'(if_rdata[1]),  64'(32'hA5A5_0002));
    if_req[1] = 1'b0; mem_req[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, fixed-latency SRAM between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage). It grants one requester at a time and sequences each access over a programmable number of wait cycles. It returns read data with a one-cycle ready pulse and produces stall signals that the top level ORs into the pipeline freeze. It sits between IF_stage/MEM_stage and the external SRAM pins at the ARM top level.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WAIT_CYCLES, 4, SRAM access cycles per transfer (>=1)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, registered
- if_ready  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  if_req & ~if_ready (combinational)
- mem_req  in  1  data request; held until mem_ready
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  write data
- mem_rdata  out  DATA_W  load data, registered
- mem_ready  out  1  one-cycle completion pulse for data port
- mem_stall  out  1  mem_req & ~mem_ready (combinational)
- sram_addr  out  ADDR_W  latched address of current access
- sram_wdata  out  DATA_W  latched write data
- sram_we  out  1  write strobe, high through ACCESS of a write
- sram_oe  out  1  output enable, high through ACCESS of a read
- sram_rdata  in  DATA_W  SRAM read bus

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the port not granted last (last_grant register, round-robin).
  - On grant, latch grant id, address, we (IF always read) and wdata into sram_* registers, clear cnt, go to ACCESS.
- ACCESS:
  - sram_oe = ~lat_we and sram_we = lat_we, both decoded from the state register. sram_addr and sram_wdata are held constant.
  - cnt increments each cycle.
  - When cnt == WAIT_CYCLES-1:
    - For a read, capture sram_rdata into the granted port's rdata register.
    - Update last_grant and go to DONE.
- DONE:
  - Assert the granted port's ready for one cycle.
  - sram_we and sram_oe are 0.
  - Go to IDLE unconditionally. A new grant is evaluated in the following IDLE cycle.
- Writes never modify mem_rdata. Each rdata register holds its value until that port's next completed read.
- A request dropped mid-access is not aborted: the access completes and ready still pulses. Requesters must hold req, addr and data stable until ready.
- Requests arriving during ACCESS/DONE wait; no queueing beyond the held request lines.
- cnt width is clog2(WAIT_CYCLES)+1; no wrap occurs before the terminal compare.

## Timing
- Reset (rst = 0, asynchronous) forces:
  - state IDLE, cnt 0
  - last_grant = IF, so the first tie grants MEM
  - if_rdata, mem_rdata, sram_addr and sram_wdata = 0
  - sram_we, sram_oe, if_ready and mem_ready = 0
  - If a request is still held, if_stall/mem_stall equal that req.
- Request asserted in IDLE in cycle 0:
  - ACCESS occupies cycles 1..WAIT_CYCLES.
  - ready is high in cycle WAIT_CYCLES+1, with rdata valid in that same cycle.
  - Occupancy per transfer is WAIT_CYCLES+2 cycles including IDLE.
- The stall for the requesting port is high from cycle 0 through cycle WAIT_CYCLES and low during the ready cycle.
- Reset asserted mid-ACCESS: the access is abandoned with no ready pulse and sram strobes drop immediately. After reset release, a still-held request restarts with full latency.

## Test plan
- Reset: hold rst = 0 for 3 cycles with both req high. All registered outputs are 0; if_stall = mem_stall = 1.
- Single fetch (WAIT_CYCLES=4):
  - Stimulus: if_addr=0x10, sram_rdata=0xE3A00001.
  - sram_oe is high in cycles 1-4 with sram_addr=0x10.
  - if_ready is high in cycle 5 only, with if_rdata=0xE3A00001.
  - if_stall is high in cycles 0-4.
- Data write:
  - Stimulus: mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF.
  - sram_we is high in cycles 1-4 with addr and data held.
  - mem_ready is high in cycle 5; mem_rdata is unchanged.
- Contention from reset:
  - Stimulus: both req high in cycle 0.
  - MEM read completes with mem_ready in cycle 5. IF is granted in cycle 6, with if_ready in cycle 11.
  - A second simultaneous pair is granted MEM first again, per round-robin.
- Reset mid-access: drive rst=0 in cycle 2 of a fetch, release in cycle 4, keep if_req held. if_ready is never pulsed before release; if_ready is high 5 cycles after the first IDLE cycle post-release.
- WAIT_CYCLES=1 build: single read has sram_oe in cycle 1 only and ready in cycle 2. Back-to-back alternating requests give ready every 3 cycles.
